// File: rtl/mac_acc_pipe.sv
// Pipelined dot-product MAC: pr lanes of a*b per beat, reduced by an adder tree,
// then accumulated over a group of beats closed by in_last or by max_beats.
module mac_acc_pipe #(
    parameter int bw        = 8,
    parameter int pr        = 8,
    parameter int psum_bw   = 2*bw + $clog2(pr),
    parameter int max_beats = 16,
    parameter int acc_bw    = psum_bw + $clog2(max_beats),
    parameter int cnt_bw    = $clog2(max_beats) + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic                     clear,
    input  logic [pr*bw-1:0]         a,
    input  logic [pr*bw-1:0]         b,
    input  logic                     is_signed,
    input  logic                     reconfigure,
    output logic                     out_valid,
    output logic signed [acc_bw-1:0] out,
    output logic [cnt_bw-1:0]        out_count,
    output logic                     out_trunc
);

    localparam int prod_bw = 2*bw;
    localparam int levels  = $clog2(pr);
    localparam logic [cnt_bw-1:0] cnt_max = cnt_bw'(max_beats);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // S1: per-lane products. b is widened by mode so one signed multiply
    // covers both the signed and the zero-extended interpretation.
    // ------------------------------------------------------------------
    logic b_signed;
    logic s1_valid_reg;
    logic s1_last_reg;
    logic signed [psum_bw-1:0] leaf [pr];

    assign b_signed = is_signed & ~reconfigure;

    genvar gi, gl;
    generate
        for (gi = 0; gi < pr; gi++) begin : g_lane
            logic [bw-1:0]             a_lane;
            logic [bw-1:0]             b_lane;
            logic signed [prod_bw-1:0] a_ext;
            logic signed [prod_bw-1:0] b_ext;
            logic signed [prod_bw-1:0] prod;
            logic signed [prod_bw-1:0] prod_reg;

            assign a_lane = a[bw*gi +: bw];
            assign b_lane = b[bw*gi +: bw];
            assign a_ext  = {{bw{a_lane[bw-1]}}, a_lane};
            assign b_ext  = {{bw{b_signed & b_lane[bw-1]}}, b_lane};
            assign prod   = a_ext * b_ext;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prod_reg <= '0;
                end else if (in_valid) begin
                    prod_reg <= prod;
                end
            end

            assign leaf[gi] = {{(psum_bw-prod_bw){prod_reg[prod_bw-1]}}, prod_reg};
        end
    endgenerate

    // A beat arriving together with clear is kept: it opens the next group.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= in_valid;
            s1_last_reg  <= in_valid & in_last;
        end
    end

    // ------------------------------------------------------------------
    // Adder tree: level gl holds pr>>(gl+1) sums of the level below.
    // ------------------------------------------------------------------
    generate
        for (gl = 0; gl < levels; gl++) begin : g_lvl
            localparam int n_sum = pr >> (gl + 1);
            logic signed [psum_bw-1:0] sum [n_sum];
            for (gi = 0; gi < n_sum; gi++) begin : g_add
                if (gl == 0) begin : g_first
                    assign sum[gi] = leaf[2*gi] + leaf[2*gi+1];
                end else begin : g_upper
                    assign sum[gi] = g_lvl[gl-1].sum[2*gi] + g_lvl[gl-1].sum[2*gi+1];
                end
            end
        end
    endgenerate

    logic signed [psum_bw-1:0] tree_root;
    assign tree_root = g_lvl[levels-1].sum[0];

    // ------------------------------------------------------------------
    // S2: registered lane sum.
    // ------------------------------------------------------------------
    logic                      s2_valid_reg;
    logic                      s2_last_reg;
    logic signed [psum_bw-1:0] psum_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            psum_reg     <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg & ~clear;
            s2_last_reg  <= s1_last_reg;
            if (s1_valid_reg) begin
                psum_reg <= tree_root;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: group FSM and accumulator.
    // ------------------------------------------------------------------
    state_t                    state_reg,     state_next;
    logic signed [acc_bw-1:0]  acc_reg,       acc_next;
    logic [cnt_bw-1:0]         cnt_reg,       cnt_next;
    logic signed [acc_bw-1:0]  out_reg,       out_next;
    logic [cnt_bw-1:0]         out_count_reg, out_count_next;
    logic                      out_trunc_reg, out_trunc_next;
    logic                      out_valid_reg, out_valid_next;

    logic signed [acc_bw-1:0]  psum_ext;
    logic signed [acc_bw-1:0]  beat_acc;
    logic [cnt_bw-1:0]         beat_cnt;
    logic                      hit_max;

    // Running value and count as they would be after absorbing the S2 beat.
    assign psum_ext = {{(acc_bw-psum_bw){psum_reg[psum_bw-1]}}, psum_reg};
    assign beat_acc = (state_reg == IDLE) ? psum_ext : acc_reg + psum_ext;
    assign beat_cnt = (state_reg == IDLE) ? cnt_bw'(1) : cnt_reg + cnt_bw'(1);
    assign hit_max  = (beat_cnt == cnt_max);

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        out_next       = out_reg;
        out_count_next = out_count_reg;
        out_trunc_next = out_trunc_reg;
        out_valid_next = 1'b0;

        if (clear) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
        end else if (s2_valid_reg) begin
            if (s2_last_reg || hit_max) begin
                out_next       = beat_acc;
                out_count_next = beat_cnt;
                out_trunc_next = ~s2_last_reg;
                out_valid_next = 1'b1;
                state_next     = IDLE;
                acc_next       = '0;
                cnt_next       = '0;
            end else begin
                state_next = ACCUM;
                acc_next   = beat_acc;
                cnt_next   = beat_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_reg       <= '0;
            out_count_reg <= '0;
            out_trunc_reg <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            out_reg       <= out_next;
            out_count_reg <= out_count_next;
            out_trunc_reg <= out_trunc_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign out_count = out_count_reg;
    assign out_trunc = out_trunc_reg;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Directed bench for mac_acc_pipe: drives beats, logs every out_valid pulse
// and compares pulses against hand-computed group results.
module tb_mac_acc_pipe;

    localparam int bw     = 8;
    localparam int pr     = 8;
    localparam int acc_bw = 23;
    localparam int cnt_bw = 5;

    logic                     clk;
    logic                     reset_n;
    logic                     in_valid;
    logic                     in_last;
    logic                     clear;
    logic [pr*bw-1:0]         a;
    logic [pr*bw-1:0]         b;
    logic                     is_signed;
    logic                     reconfigure;
    logic                     out_valid;
    logic signed [acc_bw-1:0] out;
    logic [cnt_bw-1:0]        out_count;
    logic                     out_trunc;

    mac_acc_pipe dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .clear       (clear),
        .a           (a),
        .b           (b),
        .is_signed   (is_signed),
        .reconfigure (reconfigure),
        .out_valid   (out_valid),
        .out         (out),
        .out_count   (out_count),
        .out_trunc   (out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     cyc;
        longint val;
        int     cnt;
        int     trunc;
    } pulse_t;

    pulse_t pq[$];

    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            pulse_t p;
            p.cyc   = cyc;
            p.val   = longint'(out);
            p.cnt   = int'(out_count);
            p.trunc = int'(out_trunc);
            pq.push_back(p);
            $display("pulse cyc=%0d out=%0d count=%0d trunc=%0d", p.cyc, p.val, p.cnt, p.trunc);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [pr*bw-1:0] rep(input logic [bw-1:0] v);
        return {pr{v}};
    endfunction

    task automatic beat(input logic [pr*bw-1:0] av, input logic [pr*bw-1:0] bv,
                        input bit sgn, input bit rcfg, input bit lst, input bit clr,
                        output int k);
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        a           = av;
        b           = bv;
        is_signed   = sgn;
        reconfigure = rcfg;
        in_last     = lst;
        clear       = clr;
        k           = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            clear    = 1'b0;
        end
    endtask

    task automatic expect_pulse(input string tag, input int ecyc, input longint val,
                                input int cnt, input int trunc);
        pulse_t p;
        if (pq.size() == 0) begin
            check({tag, "_present"}, 0, 1);
            return;
        end
        p = pq.pop_front();
        check({tag, "_cycle"}, p.cyc, ecyc);
        check({tag, "_out"},   p.val, val);
        check({tag, "_count"}, p.cnt, cnt);
        check({tag, "_trunc"}, p.trunc, trunc);
    endtask

    task automatic expect_empty(input string tag);
        check({tag, "_extra_pulses"}, pq.size(), 0);
        pq.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_out"},   longint'(out), 0);
        check({tag, "_count"}, out_count, 0);
        check({tag, "_trunc"}, out_trunc, 0);
    endtask

    int k0, k1, k2, kl;
    int ks[7];
    logic [pr*bw-1:0] av_t [7];
    logic [pr*bw-1:0] bv_t [7];
    bit               sg_t [7];
    bit               rc_t [7];
    longint           ex_t [7];

    initial begin
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        clear       = 1'b0;
        a           = '0;
        b           = '0;
        is_signed   = 1'b0;
        reconfigure = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // Single max-positive beat: 8 * 127 * 127
        beat(rep(8'h7F), rep(8'h7F), 1, 0, 1, 0, k0);
        idle(6);
        expect_pulse("t1", k0 + 3, 129032, 1, 0);
        expect_empty("t1");

        // -128 lanes under the three mode combinations
        beat(rep(8'h80), rep(8'h80), 1, 0, 1, 0, k0);
        beat(rep(8'h80), rep(8'h80), 1, 1, 1, 0, k1);
        beat(rep(8'h80), rep(8'h80), 0, 0, 1, 0, k2);
        idle(6);
        expect_pulse("t2_signed", k0 + 3, 131072, 1, 0);
        expect_pulse("t2_reconf", k1 + 3, -131072, 1, 0);
        expect_pulse("t2_unsign", k2 + 3, -131072, 1, 0);
        expect_empty("t2");

        // 4-beat group, each beat 8 * 1 * 2
        for (int i = 0; i < 4; i++) beat(rep(8'h01), rep(8'h02), 1, 0, (i == 3), 0, kl);
        idle(6);
        expect_pulse("t3", kl + 3, 64, 4, 0);
        expect_empty("t3");

        // 20 beats with one in_last: truncation at 16, remainder of 4
        for (int i = 1; i <= 20; i++) begin
            beat(rep(8'h01), rep(8'h01), 1, 0, (i == 20), 0, kl);
            if (i == 16) k0 = kl;
        end
        idle(6);
        expect_pulse("t4_first",  k0 + 3, 128, 16, 1);
        expect_pulse("t4_second", kl + 3, 32, 4, 0);
        expect_empty("t4");

        // Reset mid-pipe discards the partial group
        beat(rep(8'h01), rep(8'h01), 1, 0, 0, 0, k0);
        beat(rep(8'h01), rep(8'h01), 1, 0, 0, 0, k1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_outputs_zero("t5_in_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(5);
        expect_empty("t5_stale");
        beat(rep(8'h01), rep(8'h03), 1, 0, 1, 0, kl);
        idle(6);
        expect_pulse("t5", kl + 3, 24, 1, 0);
        expect_empty("t5");

        // clear with a concurrent beat restarts the group from that beat
        for (int i = 0; i < 3; i++) beat(rep(8'h01), rep(8'h01), 1, 0, 0, 0, k0);
        beat(rep(8'h01), rep(8'h01), 1, 0, 0, 1, k1);
        beat(rep(8'h01), rep(8'h01), 1, 0, 1, 0, kl);
        idle(6);
        expect_pulse("t6", kl + 3, 16, 2, 0);
        expect_empty("t6");

        // Back-to-back 1-beat groups with per-beat modes
        av_t[0] = rep(8'h80); bv_t[0] = rep(8'h80); sg_t[0] = 1; rc_t[0] = 0; ex_t[0] = 131072;
        av_t[1] = rep(8'h80); bv_t[1] = rep(8'h80); sg_t[1] = 0; rc_t[1] = 0; ex_t[1] = -131072;
        av_t[2] = rep(8'h7F); bv_t[2] = rep(8'hFF); sg_t[2] = 1; rc_t[2] = 0; ex_t[2] = -1016;
        av_t[3] = rep(8'h7F); bv_t[3] = rep(8'hFF); sg_t[3] = 1; rc_t[3] = 1; ex_t[3] = 259080;
        av_t[4] = rep(8'hFF); bv_t[4] = rep(8'hFF); sg_t[4] = 1; rc_t[4] = 0; ex_t[4] = 8;
        av_t[5] = rep(8'hFF); bv_t[5] = rep(8'hFF); sg_t[5] = 0; rc_t[5] = 0; ex_t[5] = -2040;
        for (int i = 0; i < pr; i++) av_t[6][i*bw +: bw] = 8'(i + 1);
        bv_t[6] = rep(8'hFE); sg_t[6] = 1; rc_t[6] = 0; ex_t[6] = -72;
        for (int i = 0; i < 7; i++) beat(av_t[i], bv_t[i], sg_t[i], rc_t[i], 1, 0, ks[i]);
        idle(6);
        for (int i = 0; i < 7; i++) expect_pulse($sformatf("t7_%0d", i), ks[i] + 3, ex_t[i], 1, 0);
        expect_empty("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_acc_pipe.md
Name: mac_acc_pipe

Overview:
- Pipelined, parametrised successor to the 8-lane combinational dot-product MAC.
- Each valid beat multiplies `pr` lanes of `a` by `b` and reduces them to a partial sum.
- The partial sum is accumulated across a group of beats ended by `in_last`; one result is emitted per group.
- Sits between the activation/weight feed and the psum SRAM writeback of the reconfigurable core. Keeps the per-beat signed/reconfigure mode semantics.

Parameters:
- bw, 8: lane operand width (bits).
- pr, 8: lanes per beat; power of 2, at least 2.
- psum_bw, 2*bw+$clog2(pr) (=19): per-beat partial-sum width.
- max_beats, 16: maximum beats per group; power of 2.
- acc_bw, psum_bw+$clog2(max_beats) (=23): accumulator/output width.
- cnt_bw, $clog2(max_beats)+1 (=5): beat-count width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat present this cycle.
- in_last  in  1  final beat of group; qualified by in_valid.
- clear  in  1  synchronous abort of the in-progress group.
- a  in  pr*bw  lane i at [bw*(i+1)-1:bw*i].
- b  in  pr*bw  lane i at [bw*(i+1)-1:bw*i].
- is_signed  in  1  per-beat: b treated as signed.
- reconfigure  in  1  per-beat: forces b unsigned regardless of is_signed.
- out_valid  out  1  one-cycle pulse, group result valid.
- out  out  acc_bw  signed group sum.
- out_count  out  cnt_bw  beats in emitted group (1..max_beats).
- out_trunc  out  1  group was closed by max_beats, not by in_last.

Behaviour:
- Operand rules:
  - a is always two's-complement signed.
  - b is signed iff is_signed=1 and reconfigure=0; otherwise zero-extended.
  - Products are 2*bw signed. The lane sum is sign-extended to psum_bw and is exact (no overflow possible).
- Mode is sampled with each beat and travels with it; mode changes between beats of one group are legal and take effect per beat.
- Pipeline: S1 registers the pr products; S2 registers the adder-tree sum; S3 updates the accumulator.
- Latency: a beat accepted at edge t affects the accumulator at edge t+3. A closing beat asserts out_valid in the cycle after edge t+3 (exactly 3 cycles after the input cycle).
- No backpressure: every in_valid beat is accepted. The pipe accepts 1 beat/cycle indefinitely.
- Group FSM at S3, states IDLE and ACCUM:
  - IDLE + beat: acc <= psum, cnt <= 1. Go to ACCUM, or emit and stay IDLE if the beat closes the group.
  - ACCUM + beat: acc <= acc + sign-extended psum, cnt <= cnt+1.
  - A beat closes the group if in_last=1, or if cnt reaches max_beats. In the latter case out_trunc=1 and the next beat starts a new group.
  - ACCUM with no beat: hold.
- Emit: out <= final acc (including the closing beat); out_count <= final cnt; out_valid=1 for one cycle. out and out_count hold until the next emit.
- Groups may close on consecutive cycles; out_valid may then be high every cycle.
- clear:
  - Invalidates S1/S2 beats and returns the FSM to IDLE with acc/cnt zeroed.
  - A beat presented in the same cycle as clear is kept and becomes beat 1 of a new group.
  - clear never produces out_valid.
- Reset (async, any time, including mid-group):
  - All pipe valids cleared; FSM to IDLE.
  - out=0, out_count=0, out_trunc=0, out_valid=0, acc=0.
  - Partial groups are discarded.
- Arithmetic is two's-complement and wraps at acc_bw. It cannot overflow within max_beats beats.

Test Plan:
- Single beat, all lanes a=0x7F, b=0x7F, is_signed=1, reconfigure=0, in_last=1 at cycle t -> out_valid at t+3 only; out=129032; out_count=1; out_trunc=0.
- All lanes a=0x80, b=0x80, is_signed=1, reconfigure=0, last -> out=131072. Repeat with reconfigure=1 -> out=-131072. Repeat with is_signed=0 -> out=-131072.
- 4 consecutive beats, lanes a=1, b=2, last on 4th -> a single out_valid 3 cycles after beat 4; out=64; out_count=4; no pulses for beats 1-3.
- 20 beats, a=1, b=1, in_last only on beat 20 -> first pulse (after beat 16): out=128, out_count=16, out_trunc=1. Second pulse (after beat 20): out=32, out_count=4, out_trunc=0.
- 2 beats of a 3-beat group, then reset_n low 1 cycle mid-pipe, then a fresh 1-beat group a=1, b=3 -> no stale pulse; out=24, out_count=1. During reset: all outputs 0 asynchronously.
- clear with a concurrent beat (a=1, b=1) after 3 beats, then last on the next beat -> single pulse out=16, out_count=2. Also: 1-beat groups on every cycle with mode toggling each beat -> out_valid high continuously; each out matches its beat's mode.
